// File: rtl/stage_accumulator_pkg.sv
// Shared types and constants for the stage accumulator.
package stage_accumulator_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/signed_comparator.sv
// Signed magnitude compare: gt = (A > B) treating both operands as two's complement.
module signed_comparator
    import stage_accumulator_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         gt
);

    assign gt = $signed(A) > $signed(B);

endmodule

// File: rtl/stage_accumulator.sv
// Accumulates per-feature votes over one stage and compares the total to a stage threshold.
//
// state  | meaning
// IDLE   | waiting for start; pass holds the last stage result
// ACCUM  | accepting features, adding the selected vote each acceptance
// DECIDE | compare accumulator against latched stage threshold
// DONE   | one-cycle done pulse, pass valid
module stage_accumulator
    import stage_accumulator_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  stage_len,
    input  logic [DATA_W-1:0] stage_thresh,
    input  logic              feat_valid,
    output logic              feat_ready,
    input  logic [DATA_W-1:0] feat_val,
    input  logic [DATA_W-1:0] feat_thresh,
    input  logic [DATA_W-1:0] left_val,
    input  logic [DATA_W-1:0] right_val,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  thresh_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   cnt_next;
    logic [DATA_W-1:0]  vote;
    logic               feat_gt;
    logic               stage_gt;
    logic               accept;

    signed_comparator #(.W(DATA_W)) u_feat_cmp (
        .A  (feat_val),
        .B  (feat_thresh),
        .gt (feat_gt)
    );

    signed_comparator #(.W(DATA_W)) u_stage_cmp (
        .A  (acc),
        .B  (thresh_q),
        .gt (stage_gt)
    );

    assign vote     = feat_gt ? right_val : left_val;
    assign cnt_next = cnt + 8'd1;
    assign accept   = feat_valid && feat_ready;

    // Outputs are registered alongside the state so they change only on state entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            len_q      <= '0;
            thresh_q   <= '0;
            pass       <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            feat_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        pass     <= 1'b0;
                        len_q    <= stage_len;
                        thresh_q <= stage_thresh;
                        busy     <= 1'b1;
                        if (stage_len == '0) begin
                            state <= DECIDE;
                        end else begin
                            state      <= ACCUM;
                            feat_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + vote;
                        cnt <= cnt_next;
                        if (cnt_next == len_q) begin
                            state      <= DECIDE;
                            feat_ready <= 1'b0;
                        end
                    end
                end
                DECIDE: begin
                    pass  <= stage_gt;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    feat_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_accumulator.sv
// Table-driven bench for stage_accumulator with a done-event scoreboard.
module tb_stage_accumulator;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  stage_len;
    logic [31:0] stage_thresh;
    logic        feat_valid;
    logic        feat_ready;
    logic [31:0] feat_val;
    logic [31:0] feat_thresh;
    logic [31:0] left_val;
    logic [31:0] right_val;
    logic        busy;
    logic        done;
    logic        pass;

    stage_accumulator dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stage_len    (stage_len),
        .stage_thresh (stage_thresh),
        .feat_valid   (feat_valid),
        .feat_ready   (feat_ready),
        .feat_val     (feat_val),
        .feat_thresh  (feat_thresh),
        .left_val     (left_val),
        .right_val    (right_val),
        .busy         (busy),
        .done         (done),
        .pass         (pass)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] fv;
        logic [31:0] ft;
        logic [31:0] lv;
        logic [31:0] rv;
    } feat_t;

    typedef struct {
        logic [7:0]  len;
        logic [31:0] th;
        int          first;
        int          gap;
        logic        exp_pass;
    } stage_t;

    typedef struct {
        logic exp_pass;
        int   exp_cyc;
        int   exp_acc;
    } sb_t;

    feat_t  ft_tab[12];
    stage_t st_tab[6];
    sb_t    sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     acc_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Done-event monitor: pops one expectation per done pulse.
    sb_t e;
    always @(negedge clock) begin
        if (reset) acc_seen = 0;
        else if (feat_valid && feat_ready) acc_seen++;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("pass", 32'(pass), 32'(e.exp_pass));
                check("done_cycle", 32'(cyc), 32'(e.exp_cyc));
                check("accepts", 32'(acc_seen), 32'(e.exp_acc));
                check("busy_in_done", 32'(busy), 32'd1);
                acc_seen = 0;
            end
        end
    end

    task automatic set_feat(input feat_t x);
        feat_val    = x.fv;
        feat_thresh = x.ft;
        left_val    = x.lv;
        right_val   = x.rv;
    endtask

    task automatic set_garbage();
        feat_val    = 32'h7000_0000;
        feat_thresh = 32'h0000_0000;
        left_val    = 32'hF000_0000;
        right_val   = 32'hF000_0000;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic run_stage(input int i);
        stage_t s;
        feat_t  x;
        int     n;
        s = st_tab[i];
        @(posedge clock); #1;
        start        = 1'b1;
        stage_len    = s.len;
        stage_thresh = s.th;
        @(posedge clock); #1;
        start        = 1'b0;
        stage_len    = 8'hFF;
        stage_thresh = s.exp_pass ? 32'h7FFF_FFFF : 32'h8000_0000;
        if (s.len == 8'd0) begin
            feat_valid = 1'b1;
            set_garbage();
            sb.push_back('{s.exp_pass, cyc + 1, 0});
        end
        for (int f = 0; f < int'(s.len); f++) begin
            x = ft_tab[s.first + f];
            set_feat(x);
            feat_valid = 1'b1;
            n = 0;
            @(negedge clock);
            while (!feat_ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            if (!feat_ready) check("ready_timeout", 32'd0, 32'd1);
            @(posedge clock); #1;
            if (f == int'(s.len) - 1) sb.push_back('{s.exp_pass, cyc + 1, int'(s.len)});
            feat_valid = 1'b0;
            set_garbage();
            if (f != int'(s.len) - 1) begin
                repeat (s.gap) begin
                    @(posedge clock); #1;
                end
            end
        end
        wait_drain();
        feat_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset        = 1'b1;
        start        = 1'b0;
        stage_len    = 8'd0;
        stage_thresh = 32'd0;
        feat_valid   = 1'b0;
        feat_val     = 32'd0;
        feat_thresh  = 32'd0;
        left_val     = 32'd0;
        right_val    = 32'd0;

        ft_tab[0]  = '{32'd5, 32'd0, 32'd4, 32'd7};
        ft_tab[1]  = '{-32'sd3, -32'sd3, 32'd2, 32'd9};
        ft_tab[2]  = '{32'd100, -32'sd100, -32'sd1, 32'd6};
        ft_tab[3]  = '{-32'sd9348, 32'd754, -32'sd5, 32'd50};
        ft_tab[4]  = '{32'd1, 32'd2, -32'sd10, 32'd20};
        ft_tab[5]  = '{32'd3, 32'd3, 32'd5, 32'd100};
        ft_tab[6]  = '{32'd1, 32'd0, 32'd0, 32'h7FFF_FFFF};
        ft_tab[7]  = '{32'd1, 32'd0, 32'd0, 32'h7FFF_FFFF};
        ft_tab[8]  = '{-32'sd1, 32'd0, -32'sd50, 32'd1};
        ft_tab[9]  = '{32'd0, -32'sd1, -32'sd50, -32'sd30};
        ft_tab[10] = '{32'd7, 32'd7, -32'sd10, 32'd99};
        ft_tab[11] = '{32'h8000_0000, 32'h7FFF_FFFF, -32'sd9, 32'd0};

        // len, thresh, first feature, gap, expected pass
        st_tab[0] = '{8'd3, 32'd10,      0, 0, 1'b1};  // 7+2+6=15 > 10
        st_tab[1] = '{8'd1, -32'sd5,     3, 0, 1'b0};  // -5 > -5 false
        st_tab[2] = '{8'd2, -32'sd6,     4, 4, 1'b1};  // -10+5=-5 > -6
        st_tab[3] = '{8'd0, -32'sd1,     0, 0, 1'b1};  // 0 > -1
        st_tab[4] = '{8'd2, 32'd0,       6, 0, 1'b0};  // wraps to -2
        st_tab[5] = '{8'd4, -32'sd100,   8, 0, 1'b1};  // -99 > -100

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", 32'({busy, feat_ready, done, pass}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_stage(i);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("pass_hold", 32'(pass), 32'd1);
        check("idle_not_busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_clears_pass", 32'(pass), 32'd0);

        // Abort mid-ACCUM, then start on the first cycle after reset drops.
        @(posedge clock); #1;
        start = 1'b1; stage_len = 8'd3; stage_thresh = 32'd0;
        @(posedge clock); #1;
        start = 1'b0;
        set_feat('{32'd1, 32'd0, 32'd0, 32'd5});
        feat_valid = 1'b1;
        @(posedge clock); #1;
        feat_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_outputs", 32'({busy, feat_ready, done, pass}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b1; stage_len = 8'd1; stage_thresh = -32'sd1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check("start_after_reset", 32'({busy, feat_ready}), 32'd3);
        set_feat('{32'd0, 32'd0, 32'd0, 32'd0});
        feat_valid = 1'b1;
        @(posedge clock); #1;
        sb.push_back('{1'b1, cyc + 1, 1});
        feat_valid = 1'b0;
        wait_drain();

        // Start held high through a whole stage.
        @(posedge clock); #1;
        start = 1'b1; stage_len = 8'd2; stage_thresh = 32'd0;
        @(posedge clock); #1;
        set_feat('{32'd1, 32'd0, 32'd0, 32'd1});
        feat_valid = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        k = cyc;
        sb.push_back('{1'b1, k + 1, 2});
        feat_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check("idle_after_done", 32'(busy), 32'd0);
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check("restart_on_idle", 32'({busy, feat_ready}), 32'd3);
        set_feat('{32'd0, 32'd0, -32'sd1, 32'd5});
        feat_valid = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        sb.push_back('{1'b0, cyc + 1, 2});
        feat_valid = 1'b0;
        wait_drain();

        repeat (4) @(posedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
